// File: rtl/lcd_inst_pkg.sv
// lcd_inst_pkg: shared character constants, parser state type and byte classifiers
package lcd_inst_pkg;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_S = 8'h53;
  localparam logic [7:0] ASCII_s = 8'h73;
  localparam logic [7:0] _0 = 8'h30;
  localparam logic [7:0] _1 = 8'h31;
  localparam logic [7:0] _2 = 8'h32;
  localparam logic [7:0] _3 = 8'h33;
  localparam logic [7:0] _4 = 8'h34;
  localparam logic [7:0] _5 = 8'h35;
  localparam logic [7:0] _6 = 8'h36;
  localparam logic [7:0] _7 = 8'h37;
  localparam logic [7:0] _8 = 8'h38;
  localparam logic [7:0] _9 = 8'h39;
  typedef enum logic [1:0] {IDLE, GOT_S, GOT_DIGIT, HOLD} parser_state_t;
  function automatic logic is_s_char(input logic [7:0] b);
    return b == ASCII_S || b == ASCII_s;
  endfunction
  function automatic logic is_term_char(input logic [7:0] b);
    return b == ASCII_CR || b == ASCII_LF;
  endfunction
endpackage

// File: rtl/ascii_digit_decode.sv
// ascii_digit_decode: classifies an ASCII byte as a decimal digit and returns its value
module ascii_digit_decode
  import lcd_inst_pkg::*;
(
  input  logic [7:0] byte_in,
  output logic       is_digit,
  output logic [3:0] value
);
  always_comb begin
    is_digit = byte_in >= _0 && byte_in <= _9;
    value = is_digit ? byte_in[3:0] : 4'd0;
  end
endmodule

// File: rtl/ascii_speed_parser.sv
// ascii_speed_parser: decodes "S<digit><CR|LF>" frames into a clamped speed with valid/ready handshakes
module ascii_speed_parser
  import lcd_inst_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int MAX_SPEED = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [3:0] speed,
  output logic       speed_valid,
  input  logic       speed_ready,
  output logic       frame_err,
  output logic       clamped
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [3:0] MAX4 = 4'(MAX_SPEED);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  parser_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] digit_q, digit_d, speed_q, speed_d;
  logic clamped_q, clamped_d, frame_err_q, frame_err_d;
  logic is_digit, is_s, is_term, acc, active, timeout, load;
  logic [3:0] value;
  ascii_digit_decode u_dec (
    .byte_in (rx_data),
    .is_digit(is_digit),
    .value   (value)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      digit_q <= '0;
      speed_q <= '0;
      clamped_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      digit_q <= digit_d;
      speed_q <= speed_d;
      clamped_q <= clamped_d;
      frame_err_q <= frame_err_d;
    end
  end
  always_comb begin
    is_s = is_s_char(rx_data);
    is_term = is_term_char(rx_data);
    acc = rx_valid && rx_ready;
    active = state_q == GOT_S || state_q == GOT_DIGIT;
    timeout = active && !acc && cnt_q == LAST;
    case (state_q)
      IDLE:      state_d = acc && is_s ? GOT_S : IDLE;
      GOT_S:     state_d = timeout ? IDLE : !acc ? GOT_S : is_s ? GOT_S : is_digit ? GOT_DIGIT : IDLE;
      GOT_DIGIT: state_d = timeout ? IDLE : !acc ? GOT_DIGIT : is_term ? HOLD : is_s ? GOT_S : IDLE;
      default:   state_d = speed_ready ? IDLE : HOLD;
    endcase
  end
  always_comb begin
    load = state_q == GOT_DIGIT && acc && is_term;
    digit_d = state_q == GOT_S && acc && is_digit ? value : digit_q;
    speed_d = load ? (digit_q > MAX4 ? MAX4 : digit_q) : speed_q;
    clamped_d = load ? digit_q > MAX4 : clamped_q;
    frame_err_d = timeout || (acc && !is_s && ((state_q == GOT_S && !is_digit) || (state_q == GOT_DIGIT && !is_term)));
    cnt_d = active && !acc && !timeout ? cnt_q + 1'b1 : '0;
  end
  always_comb begin
    rx_ready = rst_n && state_q != HOLD;
    speed_valid = state_q == HOLD;
    speed = speed_q;
    clamped = clamped_q;
    frame_err = frame_err_q;
  end
endmodule

// File: doc/ascii_speed_parser.md
ASCII_SPEED_PARSER -- requirements
Module: ascii_speed_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50_000_000, giving the maximum idle cycles between bytes within one frame.
REQ-002 SHALL have parameter MAX_SPEED, default 5, giving the highest speed value reported.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 rx_data  input  8  ASCII byte from the upstream byte source.
REQ-006 rx_valid  input  1  rx_data valid this cycle.
REQ-007 rx_ready  output  1  parser accepts a byte; a transfer occurs when rx_valid and rx_ready are both 1.
REQ-008 speed  output  4  decoded speed, 0..MAX_SPEED, held until the next accepted frame.
REQ-009 speed_valid  output  1  new speed available; held until consumed.
REQ-010 speed_ready  input  1  consumer accepts speed; a transfer occurs when speed_valid and speed_ready are both 1.
REQ-011 frame_err  output  1  one-cycle pulse on a malformed or timed-out frame.
REQ-012 clamped  output  1  with speed_valid, frame digit exceeded MAX_SPEED.

Function
REQ-013 Frame format SHALL be 'S' or 's' (0x53/0x73), then one digit '0'-'9' (0x30-0x39), then terminator CR (0x0D) or LF (0x0A).
REQ-014 FSM states SHALL be IDLE, GOT_S, GOT_DIGIT and HOLD.
REQ-015 IDLE: 'S'/'s' -> GOT_S; any other byte is silently discarded, with no frame_err.
REQ-016 GOT_S: digit -> GOT_DIGIT and latch the digit value; 'S'/'s' -> stay in GOT_S (restart); any other byte -> frame_err pulse, -> IDLE.
REQ-017 GOT_DIGIT: CR/LF -> HOLD and load speed = min(digit, MAX_SPEED), with clamped = (digit > MAX_SPEED); 'S'/'s' -> GOT_S; any other byte -> frame_err, -> IDLE.
REQ-018 HOLD: speed_valid = 1 and rx_ready = 0; on speed_ready -> IDLE, with speed_valid deasserting on the following cycle.
REQ-019 rx_ready SHALL be 1 in IDLE, GOT_S and GOT_DIGIT.
REQ-020 Latency SHALL be exactly 1 cycle: speed_valid rises on the cycle after the terminator transfer.
REQ-021 If speed_valid and speed_ready are already high in the same cycle, speed_valid SHALL still take one full cycle in HOLD before falling (no combinational path from speed_ready to rx_ready).
REQ-022 Timeout counter SHALL clear on every accepted byte and count only in GOT_S and GOT_DIGIT.
REQ-023 When the timeout count reaches TIMEOUT_CYCLES-1 with no byte, the block SHALL pulse frame_err and go to IDLE.
REQ-024 The timeout counter SHALL be $clog2(TIMEOUT_CYCLES) bits wide and SHALL NOT wrap; it is held at 0 in IDLE and HOLD.
REQ-025 If a timeout and an accepted byte coincide, the byte SHALL win and the timeout is ignored.
REQ-026 speed and clamped SHALL retain their last value after leaving HOLD; speed changes only on entry to HOLD.
REQ-027 frame_err SHALL never be asserted in the same cycle as a HOLD entry.

Reset
REQ-028 When rst_n = 0 at a clock edge: state = IDLE, speed = 0, speed_valid = 0, clamped = 0, frame_err = 0, timeout counter = 0.
REQ-029 rx_ready SHALL be 0 while rst_n = 0 and SHALL be 1 on the first cycle after release.
REQ-030 A reset asserted mid-frame or in HOLD SHALL discard the partial or pending frame, with no speed_valid afterwards.

Structure
REQ-031 ASCII constants (digits _0.._9, ASCII_S, ASCII_s, ASCII_CR, ASCII_LF) SHALL be placed in lcd_inst_pkg, alongside the existing character constants.
REQ-032 The parser state enum type parser_state_t SHALL be placed in lcd_inst_pkg.
REQ-033 One combinational sub-module ascii_digit_decode SHALL be used: input 8-bit byte; outputs is_digit and a 4-bit value.
REQ-034 The top module SHALL contain the FSM, the timeout counter and the output registers only.

Verification
REQ-035 Reset, then bytes 'S','3',LF back-to-back with speed_ready=1 -> speed=3, clamped=0, speed_valid high exactly 1 cycle, starting 1 cycle after the LF transfer.
REQ-036 Bytes 's','8',CR -> speed=5, clamped=1; bytes 'S','5',CR -> speed=5, clamped=0.
REQ-037 Bytes 'S','x' -> frame_err pulse on the cycle after 'x' and speed unchanged; bytes 'S','S','2',LF -> speed=2 with no frame_err.
REQ-038 TIMEOUT_CYCLES=8; send 'S', then idle 8 cycles -> frame_err pulse and return to IDLE; a following '4',LF -> no speed_valid.
REQ-039 Complete frame 'S','1',CR with speed_ready=0 for 5 cycles -> speed_valid held 5 cycles with rx_ready=0 throughout; then speed_ready=1 -> release.
REQ-040 Assert rst_n=0 while in GOT_DIGIT ('S','4' sent) -> after release, sending LF produces no speed_valid, and speed=0.
